// File: rtl/divroot_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// divroot_pkg
// Shared definitions for the divide/n-th-root arbiter.
//   state_e : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   D1_W    : first operand width (dividend / radicand)
//   D2_W    : second operand width (divisor / root index)
//   FRAC_W  : fractional bits of the 10.10 result
//   DO_W    : engine result width
//   req_t   : one captured request {mode, data_1, data_2}
// ---------------------------------------------------------------------------
package divroot_pkg;

    localparam int D1_W   = 10;
    localparam int D2_W   = 3;
    localparam int FRAC_W = 10;
    localparam int DO_W   = D1_W + FRAC_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic            mode;    // 0 = divide, 1 = n-th root
        logic [D1_W-1:0] data_1;
        logic [D2_W-1:0] data_2;
    } req_t;

endpackage

// File: rtl/divroot_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Rotating priority encoder: picks the first set bit of valid_i, searching
// from ptr_i upward and wrapping modulo N.
//   valid_i [N]  : request vector
//   ptr_i   [IW] : highest-priority position (must be < N)
//   grant_o [N]  : one-hot grant, all zero when nothing is valid
//   idx_o   [IW] : index of the granted bit (0 when nothing is valid)
//   any_o        : at least one request is valid
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        int          pos;
        logic [IW-1:0] pos_idx;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int k = 0; k < N; k++) begin
            // Position ptr+k folded back into 0..N-1 (N need not be a power of two).
            pos = int'(ptr_i) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_idx = IW'(pos);
            if (!any_o && valid_i[pos_idx]) begin
                any_o            = 1'b1;
                grant_o[pos_idx] = 1'b1;
                idx_o            = pos_idx;
            end
        end
    end

endmodule

// File: rtl/divroot_arbiter.sv
// ---------------------------------------------------------------------------
// divroot_arbiter
// Shares one divide / n-th-root engine between N_REQ requesters. Requests are
// granted round-robin, one operation is in flight at a time, and the engine
// result is returned as a one-cycle pulse tagged with the requester id.
//
// Handshakes: a request transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high; req_ready is only ever high in IDLE, for the
// round-robin winner. The engine gets a single-cycle eng_in_valid strobe and
// answers with a single-cycle eng_out_valid strobe. resp_valid is a pulse
// with no backpressure.
//
// Parameters: N_REQ (2..8), TIMEOUT (WAIT cycle limit, timeout build only).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready [N]    per-requester request / grant
//   req_mode [N]               0 = divide, 1 = n-th root
//   req_data_1 [10*N]          operand 1, slice i = [10i+9:10i]
//   req_data_2 [3*N]           operand 2, slice i = [3i+2:3i]
//   eng_in_valid/mode/data_1/data_2   operation to the engine (ISSUE only)
//   eng_out_valid, eng_out_data       result from the engine (10.10)
//   resp_valid, resp_id, resp_data, resp_error   tagged response
//   busy                       FSM not in IDLE
//
// Build option: define DIVROOT_ARB_TIMEOUT_EN to abort an operation whose
// result has not arrived after TIMEOUT WAIT cycles (error response).
// ---------------------------------------------------------------------------
module divroot_arbiter
    import divroot_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1000,
    localparam int IDW    = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ-1:0]      req_mode,
    input  logic [D1_W*N_REQ-1:0] req_data_1,
    input  logic [D2_W*N_REQ-1:0] req_data_2,
    output logic                  eng_in_valid,
    output logic                  eng_in_mode,
    output logic [D1_W-1:0]       eng_in_data_1,
    output logic [D2_W-1:0]       eng_in_data_2,
    input  logic                  eng_out_valid,
    input  logic [DO_W-1:0]       eng_out_data,
    output logic                  resp_valid,
    output logic [IDW-1:0]        resp_id,
    output logic [DO_W-1:0]       resp_data,
    output logic                  resp_error,
    output logic                  busy
);

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   id_q;
    req_t             req_q;
    logic [IDW-1:0]   resp_id_q, resp_id_d;
    logic [DO_W-1:0]  resp_data_q, resp_data_d;
    logic             resp_error_q, resp_error_d;
    logic             take;
    logic             tmo_hit;

    logic [N_REQ-1:0] pick_grant;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;
    req_t             req_arr [N_REQ];
    req_t             sel_req;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign req_arr[i] = {req_mode[i],
                             req_data_1[i*D1_W +: D1_W],
                             req_data_2[i*D2_W +: D2_W]};
    end

    assign sel_req = req_arr[pick_idx];

    rr_pick #(
        .N  (N_REQ),
        .IW (IDW)
    ) u_pick (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

`ifdef DIVROOT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q;

    // Cleared while in ISSUE so it reads 0 on the first WAIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == ST_ISSUE) begin
            cnt_q <= '0;
        end else if (state_q == ST_WAIT && !eng_out_valid) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign tmo_hit        = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        req_ready    = '0;
        take         = 1'b0;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        resp_error_d = resp_error_q;
        case (state_q)
            ST_IDLE: begin
                // The winner's ready mirrors its valid, so any_o is the handshake.
                req_ready = pick_grant;
                if (pick_any) begin
                    take = 1'b1;
                    if (sel_req.data_2 == '0) begin
                        // Zero divisor / root index: answer without the engine.
                        state_d      = ST_RESP;
                        resp_id_d    = pick_idx;
                        resp_data_d  = '0;
                        resp_error_d = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A result on the final count takes precedence over timeout.
                if (eng_out_valid) begin
                    state_d      = ST_RESP;
                    resp_id_d    = id_q;
                    resp_data_d  = eng_out_data;
                    resp_error_d = 1'b0;
                end else if (tmo_hit) begin
                    state_d      = ST_RESP;
                    resp_id_d    = id_q;
                    resp_data_d  = '0;
                    resp_error_d = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            req_q        <= '0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            resp_error_q <= resp_error_d;
            if (take) begin
                req_q <= sel_req;
                id_q  <= pick_idx;
            end
            // Priority moves past the requester just answered.
            if (state_q == ST_RESP) begin
                ptr_q <= (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
            end
        end
    end

    assign eng_in_valid  = (state_q == ST_ISSUE);
    assign eng_in_mode   = eng_in_valid ? req_q.mode   : 1'b0;
    assign eng_in_data_1 = eng_in_valid ? req_q.data_1 : '0;
    assign eng_in_data_2 = eng_in_valid ? req_q.data_2 : '0;

    assign resp_valid = (state_q == ST_RESP);
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign resp_error = resp_error_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_divroot_arbiter.sv
// ---------------------------------------------------------------------------
// tb_divroot_arbiter
// Directed bench for divroot_arbiter with a behavioural engine model.
// Expected engine operations and responses are queued when stimulus is
// issued; a monitor thread pops and compares when the DUT strobes.
// Define DIVROOT_ARB_TIMEOUT_EN for both DUT and bench to exercise timeout.
// ---------------------------------------------------------------------------
module tb_divroot_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int LAT = 5;
`ifdef DIVROOT_ARB_TIMEOUT_EN
    localparam int TMO = 20;
`else
    localparam int TMO = 1000;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_mode = '0;
    logic [10*N-1:0] req_data_1 = '0;
    logic [3*N-1:0]  req_data_2 = '0;
    logic            eng_in_valid;
    logic            eng_in_mode;
    logic [9:0]      eng_in_data_1;
    logic [2:0]      eng_in_data_2;
    logic            eng_out_valid = 1'b0;
    logic [19:0]     eng_out_data = '0;
    logic            resp_valid;
    logic [IDW-1:0]  resp_id;
    logic [19:0]     resp_data;
    logic            resp_error;
    logic            busy;

    int              n_cmp = 0;
    int              n_fail = 0;
    int              cyc = 0;
    int              exp_in_cyc = -1;
    int              exp_resp_cyc = -1;
    logic            eng_silent = 1'b0;
    logic [N-1:0]    sticky = '0;
    logic            tick_resp = 1'b0;
    logic [IDW-1:0]  tick_resp_id = '0;

    logic [23:0]     exp_q[$];   // {id[2:0], data[19:0], error}
    logic [13:0]     eng_q[$];   // {mode, data_1, data_2}

    divroot_arbiter #(
        .N_REQ   (N),
        .TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_mode      (req_mode),
        .req_data_1    (req_data_1),
        .req_data_2    (req_data_2),
        .eng_in_valid  (eng_in_valid),
        .eng_in_mode   (eng_in_mode),
        .eng_in_data_1 (eng_in_data_1),
        .eng_in_data_2 (eng_in_data_2),
        .eng_out_valid (eng_out_valid),
        .eng_out_data  (eng_out_data),
        .resp_valid    (resp_valid),
        .resp_id       (resp_id),
        .resp_data     (resp_data),
        .resp_error    (resp_error),
        .busy          (busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint ipow(input int x, input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * x;
            if (p > 2048) return p;
        end
        return p;
    endfunction

    // Engine behaviour: 10.10 quotient, or integer n-th root in 10.10 form.
    function automatic logic [19:0] eng_model(input logic m, input logic [9:0] a, input logic [2:0] b);
        logic [19:0] r;
        int          k;
        if (!m) begin
            r = {a, 10'b0} / {17'b0, b};
        end else begin
            k = 0;
            while (ipow(k + 1, int'(b)) <= longint'(a)) k++;
            r = 20'(k) << 10;
        end
        return r;
    endfunction

    // ---------------- engine model ----------------
    task automatic engine();
        logic [19:0] res;
        logic        aborted;
        forever begin
            @(negedge clk);
            if (rst_n && eng_in_valid && !eng_silent) begin
                res     = eng_model(eng_in_mode, eng_in_data_1, eng_in_data_2);
                aborted = 1'b0;
                for (int i = 0; i < LAT; i++) begin
                    @(posedge clk);
                    #1;
                    if (!rst_n) aborted = 1'b1;
                end
                if (!aborted) begin
                    eng_out_valid = 1'b1;
                    eng_out_data  = res;
                    @(posedge clk);
                    #1;
                    eng_out_valid = 1'b0;
                end
            end
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic monitor();
        logic [N-1:0] hs;
        logic [23:0]  e;
        int           gid;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                hs = req_valid & req_ready;
                if (hs != '0) begin
                    chk("ready_onehot", $countones(hs), 1);
                    gid = 0;
                    for (int i = 0; i < N; i++) if (hs[i]) gid = i;
                    if (req_data_2[3*gid +: 3] == 3'd0) exp_resp_cyc = cyc + 1;
                    else                               exp_in_cyc   = cyc + 1;
                end
                if (eng_in_valid) begin
                    chk("eng_in_cycle", cyc, exp_in_cyc);
                    if (eng_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL eng_unexpected: got strobe expected none (t=%0t)", $time);
                    end else begin
                        chk("eng_ops", {eng_in_mode, eng_in_data_1, eng_in_data_2}, eng_q.pop_front());
                    end
                    if (eng_silent) exp_resp_cyc = cyc + TMO + 1;
                end
                if (eng_out_valid && busy) exp_resp_cyc = cyc + 1;
                if (resp_valid) begin
                    chk("resp_cycle", cyc, exp_resp_cyc);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL resp_unexpected: got id %0d data 0x%0h err %0b expected none",
                                 resp_id, resp_data, resp_error);
                    end else begin
                        e = exp_q.pop_front();
                        chk("resp", {1'b0, resp_id, resp_data, resp_error}, e);
                    end
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        logic [N-1:0] hs;
        @(negedge clk);
        hs           = req_valid & req_ready;
        tick_resp    = resp_valid;
        tick_resp_id = resp_id;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~(hs & ~sticky);
    endtask

    task automatic set_req(input int id, input logic m, input logic [9:0] d1, input logic [2:0] d2);
        req_mode[id]          = m;
        req_data_1[10*id +: 10] = d1;
        req_data_2[3*id +: 3]   = d2;
        req_valid[id]         = 1'b1;
    endtask

    task automatic push_resp(input int id, input logic [19:0] d, input logic err);
        exp_q.push_back({3'(id), d, err});
    endtask

    task automatic wait_done(input int budget, input string name);
        int  n;
        logic done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            tick();
            n++;
            done = (req_valid == '0) && !busy && (exp_q.size() == 0) && (eng_q.size() == 0);
        end
        chk(name, 32'(done), 32'd1);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_busy"},    32'(busy), 0);
        chk({name, "_ready"},   32'(req_ready), 0);
        chk({name, "_eng_in"},  {eng_in_valid, eng_in_mode, eng_in_data_1, eng_in_data_2}, 0);
        chk({name, "_resp"},    {resp_valid, resp_id, resp_data, resp_error}, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int zero_seen;
        fork
            monitor();
            engine();
        join_none

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 0);

        // Single divide from requester 2: 100 / 4 = 25.0
        eng_q.push_back({1'b0, 10'd100, 3'd4});
        push_resp(2, 20'h06400, 1'b0);
        set_req(2, 1'b0, 10'd100, 3'd4);
        wait_done(100, "done_single");

        // Cube root of 512 from requester 3 = 8.0; ptr returns to 0
        eng_q.push_back({1'b1, 10'd512, 3'd3});
        push_resp(3, 20'h02000, 1'b0);
        set_req(3, 1'b1, 10'd512, 3'd3);
        wait_done(100, "done_root");
        repeat (3) tick();
        chk("resp_data_hold", resp_data, 20'h02000);
        chk("resp_valid_low", 32'(resp_valid), 0);

        // Fairness: 0, 1, 3 together with ptr 0; requester 0 stays valid
        eng_q.push_back({1'b0, 10'd10, 3'd2});
        eng_q.push_back({1'b0, 10'd7,  3'd2});
        eng_q.push_back({1'b0, 10'd1,  3'd3});
        eng_q.push_back({1'b0, 10'd10, 3'd2});
        push_resp(0, 20'h01400, 1'b0);
        push_resp(1, 20'h00E00, 1'b0);
        push_resp(3, 20'h00155, 1'b0);
        push_resp(0, 20'h01400, 1'b0);
        sticky = 4'b0001;
        set_req(0, 1'b0, 10'd10, 3'd2);
        set_req(1, 1'b0, 10'd7,  3'd2);
        set_req(3, 1'b0, 10'd1,  3'd3);
        zero_seen = 0;
        for (int i = 0; i < 200 && zero_seen < 2; i++) begin
            tick();
            if (tick_resp && tick_resp_id == 2'd0) zero_seen++;
        end
        sticky       = '0;
        req_valid[0] = 1'b0;
        chk("fair_zero_served_twice", zero_seen, 2);
        wait_done(100, "done_fair");

        // Zero divisor from requester 1: immediate error, no engine strobe
        push_resp(1, 20'h0, 1'b1);
        set_req(1, 1'b0, 10'd55, 3'd0);
        wait_done(20, "done_zero");

        // One more op from requester 1 so ptr = 2 and resp_data is non-zero
        eng_q.push_back({1'b0, 10'd7, 3'd2});
        push_resp(1, 20'h00E00, 1'b0);
        set_req(1, 1'b0, 10'd7, 3'd2);
        wait_done(100, "done_pre_reset");

        // Reset while WAITing on an op from requester 3
        eng_q.push_back({1'b0, 10'd20, 3'd4});
        set_req(3, 1'b0, 10'd20, 3'd4);
        repeat (3) tick();
        chk("wait_busy", 32'(busy), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) tick();
        chk("post_reset_idle", 32'(busy), 0);
        chk("post_reset_eng_q", eng_q.size(), 0);

        // ptr back at 0: requester 1 beats requester 2
        eng_q.push_back({1'b0, 10'd7,   3'd2});
        eng_q.push_back({1'b0, 10'd100, 3'd4});
        push_resp(1, 20'h00E00, 1'b0);
        push_resp(2, 20'h06400, 1'b0);
        set_req(1, 1'b0, 10'd7,   3'd2);
        set_req(2, 1'b0, 10'd100, 3'd4);
        wait_done(100, "done_ptr0");

        // Silent engine
        eng_silent = 1'b1;
        eng_q.push_back({1'b1, 10'd27, 3'd3});
        set_req(0, 1'b1, 10'd27, 3'd3);
`ifdef DIVROOT_ARB_TIMEOUT_EN
        push_resp(0, 20'h0, 1'b1);
        wait_done(100, "done_timeout");
`else
        repeat (60) tick();
        chk("silent_busy", 32'(busy), 1);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("silent_recover", 32'(busy), 0);
`endif
        eng_silent = 1'b0;

        chk("exp_q_empty", exp_q.size(), 0);
        chk("eng_q_empty", eng_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/divroot_arbiter.md
# divroot_arbiter

Controller that shares one divide/n-th-root engine (10-bit integer operand, 3-bit divisor/root index, 20-bit 10.10 fixed-point result) between N requesters. It grants requesters round-robin and issues one operation at a time to the engine as a single-cycle `in_valid` pulse. It waits for the engine's `out_valid`, then returns the result tagged with the requester ID. It sits between the client blocks and the shared engine instance.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 1000: WAIT-state cycle limit, used only with the timeout feature.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: per-requester request.
- `req_ready` out N_REQ: per-requester grant; request accepted when valid && ready.
- `req_mode` in N_REQ: 0 = divide, 1 = n-th root.
- `req_data_1` in 10*N_REQ: dividend/radicand, slice i = bits [10i+9:10i].
- `req_data_2` in 3*N_REQ: divisor/root index, slice i = bits [3i+2:3i].
- `eng_in_valid` out 1: operation strobe to engine.
- `eng_in_mode` out 1: operation mode to engine.
- `eng_in_data_1` out 10: first operand to engine.
- `eng_in_data_2` out 3: second operand to engine.
- `eng_out_valid` in 1: engine result strobe.
- `eng_out_data` in 20: engine result, 10.10 unsigned.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_id` out $clog2(N_REQ): requester that owns the response.
- `resp_data` out 20: result, 0 on error.
- `resp_error` out 1: zero operand or timeout.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: the winner g is the first i with `req_valid[i]`, searching from `ptr` upward and wrapping mod N_REQ. `req_ready[g]` = 1, combinational from the state and `req_valid`; all other ready bits are 0.
  - On the handshake edge, latch `mode`/`data_1`/`data_2` and `id` = g.
  - If the latched `data_2` == 0: go to RESP with error = 1 and data = 0; the engine is not started.
  - Otherwise go to ISSUE.
- ISSUE: `eng_in_valid` = 1 for exactly one cycle with the latched operands, then go to WAIT. `eng_in_*` are 0 in every state except ISSUE.
- WAIT: on the first cycle where `eng_out_valid` is high, latch `eng_out_data` and go to RESP with error = 0. `eng_out_valid` is ignored outside WAIT.
- RESP: `resp_valid` = 1 with `resp_id`/`resp_data`/`resp_error` valid for one cycle. `ptr` ← id+1 mod N_REQ. Go to IDLE.
  - No response backpressure: clients must sample the pulse.
- `req_ready` is 0 in every state other than IDLE. Requesters hold valid and operands stable until their handshake.
- `resp_*` data outputs hold their last value between pulses.

## Timing
- Reset (async assert, sync release): state = IDLE, `ptr` = 0. All outputs 0, including `req_ready`.
- Reset mid-operation: the operation is dropped and no response is emitted. The engine must be reset on the same `rst_n`.
- Handshake edge T → `eng_in_valid` high in cycle T+1 → WAIT from T+2.
- `eng_out_valid` sampled at edge E → `resp_valid` high in the cycle after E → IDLE.
- Next grant is possible in that IDLE cycle. Minimum request spacing = engine latency + 3 cycles.
- Zero-operand path: handshake T → `resp_valid` in T+1 → IDLE in T+2.
- A requester that keeps valid high after its own response is served again only after all other pending requesters have been served.

## Configuration
- Macro: `DIVROOT_ARB_TIMEOUT_EN`.
- Defined:
  - A `$clog2(TIMEOUT+1)`-bit counter clears on entry to WAIT and increments each WAIT cycle without `eng_out_valid`.
  - When it reaches TIMEOUT-1 without `eng_out_valid`: go to RESP with error = 1 and data = 0.
  - `eng_out_valid` on the final count wins over timeout.
  - Limitation: a late result from an aborted operation is indistinguishable from the next result. System software resets the block and engine after any timeout error.
- Undefined: no counter; WAIT waits indefinitely; `resp_error` is asserted only for `data_2` == 0.

## Structure
- Package `divroot_pkg` holds:
  - the state enum;
  - localparams `D1_W` = 10, `D2_W` = 3, `DO_W` = 20, `FRAC_W` = 10;
  - a request struct {mode, data_1, data_2}.
- One sub-module `rr_pick`: N_REQ-wide rotating priority encoder (valid vector, ptr → one-hot grant, index, any).

## Test plan
- Single request, requester 2, mode 0, data_1 = 100, data_2 = 4; engine model latency 5 → one `eng_in_valid` pulse with (0, 100, 4); `resp_id` = 2, `resp_data` = 0x06400 (25.0), error 0.
- Requesters 0, 1, 3 all valid at once with ptr = 0 → grant order 0, 1, 3; next grant is 0 only after 3 is served; exactly one `eng_in_valid` per op.
- data_2 = 0 from requester 1 → `resp_valid` one cycle after the handshake, error 1, data 0; `eng_in_valid` never asserts.
- Root mode, data_1 = 512, data_2 = 3 → engine sees mode 1; `resp_data` equals the engine output unchanged.
- `rst_n` low during WAIT → all outputs 0 immediately; no `resp_valid` after release; ptr = 0.
- With `DIVROOT_ARB_TIMEOUT_EN`, TIMEOUT = 20, engine silent → `resp_error` = 1 exactly 20 WAIT cycles after entry; without the macro, `busy` stays high.
